// File: rtl/pwm_capture_if.sv
// pwm_capture_if: groups the measurement control and result signals of pwm_capture.
//   enable, pwm_in                 : driven by the master (controller / test driver)
//   valid, high_cnt, period_cnt,
//   duty, stuck, overrun           : driven by the slave (pwm_capture)
interface pwm_capture_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             enable;
    logic             pwm_in;
    logic             valid;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [WIDTH-1:0] duty;
    logic             stuck;
    logic             overrun;

    modport master (
        output enable, pwm_in,
        input  valid, high_cnt, period_cnt, duty, stuck, overrun
    );

    modport slave (
        input  enable, pwm_in,
        output valid, high_cnt, period_cnt, duty, stuck, overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and normalised duty of an edge-aligned PWM input.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pwm_capture_if.slave
//                in : enable (measure / abort), pwm_in (asynchronous PWM)
//                out: valid pulse, high_cnt, period_cnt, duty, stuck, sticky overrun
//
// state    | meaning
// ST_IDLE  | disabled; counters cleared, results held
// ST_ARM   | waiting for the first rise; period_ctr runs as stuck timer
// ST_HIGH  | input high; period and high counters run
// ST_LOW   | input low; period counter runs, next rise completes the period
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               DC_W    = $clog2(WIDTH + 1);
    localparam logic [DC_W-1:0]  DC_LOAD = DC_W'(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d_q, rise, fall;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
    logic                   ovr_q, ovr_d, start, stuck_evt, busy;

    logic [DC_W-1:0]        div_cnt_q;
    logic [CNT_W-1:0]       rem_q, dvs_q, dh_q, rem_nx;
    logic [WIDTH-1:0]       quo_q, quo_nx;
    logic                   sat_q, ge;
    logic [CNT_W:0]         rem_sh;

    logic                   valid_q, stuck_q;
    logic [CNT_W-1:0]       high_cnt_q, period_cnt_q;
    logic [WIDTH-1:0]       duty_q;

    // Synchroniser runs regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_d_q  <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;
    assign busy = (div_cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            high_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        high_d    = high_q;
        ovr_d     = ovr_q;
        start     = 1'b0;
        stuck_evt = 1'b0;
        if (!bus.enable) begin
            state_d  = ST_IDLE;
            period_d = '0;
            high_d   = '0;
            ovr_d    = 1'b0;
        end else if (state_q != ST_IDLE && period_q == CNT_MAX) begin
            // Input not toggling: report a timeout and re-arm
            stuck_evt = 1'b1;
            period_d  = '0;
            high_d    = '0;
            state_d   = ST_ARM;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        state_d  = ST_HIGH;
                        period_d = CNT_W'(1);
                        high_d   = CNT_W'(1);
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    period_d = period_q + 1'b1;
                    if (fall) state_d = ST_LOW;
                    else      high_d  = high_q + 1'b1;
                end
                ST_LOW: begin
                    if (rise) begin
                        if (busy) ovr_d = 1'b1;
                        else      start = 1'b1;
                        state_d  = ST_HIGH;
                        period_d = CNT_W'(1);
                        high_d   = CNT_W'(1);
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Restoring divide step: remainder starts at high (< period), so each shifted-in
    // zero yields one fractional quotient bit of high/period.
    always_comb begin
        rem_sh = {rem_q, 1'b0};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_nx = ge ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
        quo_nx = WIDTH'({quo_q, ge});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            dh_q         <= '0;
            quo_q        <= '0;
            sat_q        <= 1'b0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty_q       <= '0;
        end else if (!bus.enable) begin
            div_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (stuck_evt) begin
                valid_q      <= 1'b1;
                stuck_q      <= 1'b1;
                high_cnt_q   <= '0;
                period_cnt_q <= '0;
                duty_q       <= s ? '1 : '0;
            end else if (start) begin
                div_cnt_q <= DC_LOAD;
                rem_q     <= high_q;
                dvs_q     <= period_q;
                dh_q      <= high_q;
                quo_q     <= '0;
                sat_q     <= (high_q >= period_q);
            end else if (busy) begin
                div_cnt_q <= div_cnt_q - 1'b1;
                rem_q     <= rem_nx;
                quo_q     <= quo_nx;
                if (div_cnt_q == DC_W'(1)) begin
                    valid_q      <= 1'b1;
                    stuck_q      <= 1'b0;
                    high_cnt_q   <= dh_q;
                    period_cnt_q <= dvs_q;
                    duty_q       <= sat_q ? '1 : quo_nx;
                end
            end
        end
    end

    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.duty       = duty_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
    localparam int W  = 8;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    pwm_capture #(.WIDTH(W), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int h;
        int p;
        int duty;
        bit stk;
        int due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    exp_t last_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    bit have_prev;
    int prev_h, prev_rise, last_acc;
    bit model_ovr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_duty(input int h, input int p);
        longint q;
        q = (longint'(h) * (longint'(1) << W)) / p;
        if (q > (1 << W) - 1) q = (1 << W) - 1;
        return int'(q);
    endfunction

    // monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("high_cnt", bus.high_cnt, mon_e.h);
                chk("period_cnt", bus.period_cnt, mon_e.p);
                chk("duty", bus.duty, mon_e.duty);
                chk("stuck", bus.stuck, mon_e.stk);
                if (mon_e.due >= 0) chk("latency_cycle", cyc, mon_e.due);
                last_e = mon_e;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int n);
        bus.pwm_in = v;
        repeat (n) step();
    endtask

    // one PWM period beginning with a rise; the rise completes the previous period
    task automatic pulse(input int h, input int l);
        int k;
        int p;
        exp_t e;
        k = cyc;
        if (have_prev) begin
            p = k - prev_rise;
            if (k - last_acc >= W + 1) begin
                e.h = prev_h; e.p = p; e.duty = exp_duty(prev_h, p); e.stk = 0; e.due = k + W + 3;
                sbq.push_back(e);
                last_acc = k;
            end else begin
                model_ovr = 1'b1;
            end
        end
        have_prev = 1'b1;
        prev_h = h;
        prev_rise = k;
        drive(1'b1, h);
        if (l > 0) drive(1'b0, l);
    endtask

    task automatic model_clear();
        have_prev = 1'b0;
        model_ovr = 1'b0;
        last_acc = -1000;
    endtask

    // results not yet on the outputs by cycle lim are lost
    task automatic drop_from(input int lim);
        while (sbq.size() > 0 && sbq[sbq.size()-1].due >= lim) void'(sbq.pop_back());
    endtask

    task automatic set_en(input bit e);
        bus.enable = e;
        if (!e) drop_from(cyc + 1);
        model_clear();
        step();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sbq.size() > 0 && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic push_stuck(input int d);
        exp_t e;
        e.h = 0; e.p = 0; e.duty = d; e.stk = 1; e.due = -1;
        sbq.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, h;
        bus.enable = 1'b0;
        bus.pwm_in = 1'b0;
        model_clear();
        repeat (3) step();
        chk("rst_valid", bus.valid, 0);
        chk("rst_high_cnt", bus.high_cnt, 0);
        chk("rst_period_cnt", bus.period_cnt, 0);
        chk("rst_duty", bus.duty, 0);
        chk("rst_stuck", bus.stuck, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst_n = 1'b1;
        step();

        // directed duties
        set_en(1'b1);
        drive(1'b0, 4);
        repeat (4) pulse(64, 192);
        repeat (3) pulse(255, 1);
        repeat (3) pulse(1, 255);
        repeat (3) pulse(30, 70);
        drive(1'b0, 2);
        drain(40);
        chk("overrun_directed", bus.overrun, model_ovr);
        set_en(1'b0);

        // randomized periods
        set_en(1'b1);
        drive(1'b0, 4);
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(300, 2);
            h = $urandom_range(p - 1, 1);
            pulse(h, p - h);
        end
        pulse(5, 5);
        drain(40);
        chk("overrun_random", bus.overrun, model_ovr);
        set_en(1'b0);
        chk("overrun_cleared_random", bus.overrun, 0);

        // periods shorter than the divide
        set_en(1'b1);
        drive(1'b0, 4);
        repeat (10) pulse(2, 3);
        drive(1'b0, 2);
        drain(40);
        chk("overrun_short", bus.overrun, model_ovr);
        chk("overrun_set", model_ovr, 1);
        set_en(1'b0);
        chk("overrun_cleared", bus.overrun, 0);

        // static input timeouts
        bus.pwm_in = 1'b0;
        set_en(1'b1);
        push_stuck(0);
        push_stuck(0);
        drain(2600);
        set_en(1'b0);
        drive(1'b1, 4);
        set_en(1'b1);
        push_stuck((1 << W) - 1);
        push_stuck((1 << W) - 1);
        drain(2600);
        set_en(1'b0);

        // abort an in-flight divide by dropping enable mid-HIGH
        drive(1'b0, 4);
        set_en(1'b1);
        drive(1'b0, 4);
        pulse(20, 20);
        pulse(20, 20);
        pulse(5, 0);
        set_en(1'b0);
        drive(1'b1, 20);
        chk("hold_high_cnt", bus.high_cnt, last_e.h);
        chk("hold_period_cnt", bus.period_cnt, last_e.p);
        chk("hold_duty", bus.duty, last_e.duty);
        chk("hold_stuck", bus.stuck, last_e.stk);

        // re-enable while high: needs a fresh rise plus one full period
        set_en(1'b1);
        drive(1'b1, 10);
        drive(1'b0, 5);
        pulse(40, 60);
        pulse(40, 60);
        pulse(10, 10);
        drain(40);

        // reset mid-HIGH
        pulse(50, 50);
        pulse(7, 0);
        rst_n = 1'b0;
        drop_from(cyc);
        model_clear();
        #1;
        chk("rstmid_valid", bus.valid, 0);
        chk("rstmid_high_cnt", bus.high_cnt, 0);
        chk("rstmid_period_cnt", bus.period_cnt, 0);
        chk("rstmid_duty", bus.duty, 0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 5);
        pulse(50, 50);
        pulse(50, 50);
        pulse(5, 5);
        drain(40);
        set_en(1'b0);
        drive(1'b0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
